// File: rtl/csa_accum_sequencer.sv
// csa_accum_sequencer
// Streams unsigned operands into a redundant sum/carry pair with a 3:2
// carry-save step per operand, then resolves the pair with one carry-propagate
// add and offers the total on a valid/ready output.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (in_ready is a Moore decode)
//   in_data, in_last      operand and end-of-transaction marker
//   out_valid/out_ready   result handshake
//   out_sum               resolved sum (ACC_W bits)
//   out_count             number of operands accumulated
//   out_ovf               operands beyond MAX_OPS were dropped
//   busy                  FSM is not idle
module csa_accum_sequencer #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_OPS = 16,
    localparam int unsigned ACC_W  = WIDTH + $clog2(MAX_OPS),
    localparam int unsigned CNT_W  = $clog2(MAX_OPS) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCUM   = 2'd1;
    localparam logic [1:0] ST_RESOLVE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [ACC_W-1:0] sum_r;
    logic [ACC_W-1:0] carry_r;
    logic [CNT_W-1:0] count;
    logic             ovf;

    logic             accept;
    logic             count_full;
    logic [ACC_W-1:0] x_ext;

    assign accept     = in_valid && in_ready;
    assign count_full = (count == CNT_W'(MAX_OPS));
    assign x_ext      = ACC_W'(in_data);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = in_last ? ST_RESOLVE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept && in_last) begin
                    next_state = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                next_state = ST_DONE;
            end
            ST_DONE: begin
                if (out_valid && out_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Registered control outputs, decoded from the state being entered.
    // out_valid rises one cycle after DONE is entered so out_sum is already
    // settled when it is first offered, and drops on the handshake edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (next_state == ST_IDLE) || (next_state == ST_ACCUM);
            busy      <= (next_state != ST_IDLE);
            out_valid <= (state == ST_DONE) && (next_state == ST_DONE);
        end
    end

    // Carry-save accumulation and final resolve
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r     <= '0;
            carry_r   <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sum_r   <= x_ext;
                        carry_r <= '0;
                        count   <= CNT_W'(1);
                        ovf     <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        if (count_full) begin
                            // operand dropped; overflow sticks for this transaction
                            ovf <= 1'b1;
                        end else begin
                            sum_r   <= sum_r ^ carry_r ^ x_ext;
                            carry_r <= ((sum_r & carry_r) | (sum_r & x_ext) |
                                        (carry_r & x_ext)) << 1;
                            count   <= count + CNT_W'(1);
                        end
                    end
                end
                ST_RESOLVE: begin
                    out_sum   <= sum_r + carry_r;
                    out_count <= count;
                    out_ovf   <= ovf;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum_sequencer.sv
// Self-checking bench for csa_accum_sequencer: directed vector table,
// hand-written multi-cycle sequences, and random transactions checked
// against a plain-arithmetic reference model.
module tb_csa_accum_sequencer;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned MAX_OPS = 16;
    localparam int unsigned ACC_W   = 8;
    localparam int unsigned CNT_W   = 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;
    logic             busy;

    int checks = 0;
    int fails  = 0;

    logic [WIDTH-1:0] cur_ops[$];

    typedef struct {
        int               n;
        logic [WIDTH-1:0] ops [20];
        int               gaps;
        int               stall;
        int               sum;
        int               cnt;
        int               ovf;
    } vec_t;

    vec_t tbl [7];

    csa_accum_sequencer #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: sum of the first MAX_OPS operands, overflow if more arrived
    function automatic void model(output int s, output int c, output int o);
        s = 0;
        c = 0;
        o = 0;
        foreach (cur_ops[i]) begin
            if (i < MAX_OPS) begin
                s += int'(cur_ops[i]);
                c++;
            end else begin
                o = 1;
            end
        end
    endfunction

    // gap_mode: 0 back-to-back, 1 one idle cycle between operands, 2 random gaps
    task automatic send_ops(input int gap_mode, input bit no_last);
        for (int i = 0; i < cur_ops.size(); i++) begin
            int guard;
            guard    = 0;
            in_valid = 1'b1;
            in_data  = cur_ops[i];
            in_last  = !no_last && (i == cur_ops.size() - 1);
            while (!in_ready && guard < 50) begin
                tick();
                guard++;
            end
            if (guard >= 50) begin
                checks++;
                fails++;
                $display("FAIL ready_timeout: in_ready stayed low for %0d cycles", guard);
            end
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_data  = WIDTH'($urandom);
            if (i != cur_ops.size() - 1) begin
                if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
                    tick();
                end
            end
        end
    endtask

    task automatic get_result(input int sum, input int cnt, input int ovf, input int stall);
        int guard;
        guard = 0;
        while (!out_valid && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) begin
            checks++;
            fails++;
            $display("FAIL valid_timeout: out_valid stayed low for %0d cycles", guard);
        end
        chk("ready_in_done", 32'(in_ready), 32'd0);
        chk("busy_in_done", 32'(busy), 32'd1);
        chk("out_sum", 32'(out_sum), 32'(sum));
        chk("out_count", 32'(out_count), 32'(cnt));
        chk("out_ovf", 32'(out_ovf), 32'(ovf));
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_sum", 32'(out_sum), 32'(sum));
            chk("stall_busy", 32'(busy), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_hs_valid", 32'(out_valid), 32'd0);
        chk("post_hs_busy", 32'(busy), 32'd0);
        chk("post_hs_ready", 32'(in_ready), 32'd1);
        chk("post_hs_sum_kept", 32'(out_sum), 32'(sum));
    endtask

    task automatic run_vec(input int t);
        cur_ops.delete();
        for (int i = 0; i < tbl[t].n; i++) cur_ops.push_back(tbl[t].ops[i]);
        send_ops(tbl[t].gaps, 1'b0);
        get_result(tbl[t].sum, tbl[t].cnt, tbl[t].ovf, tbl[t].stall);
    endtask

    task automatic set_vec(input int t, input int n, input int gaps, input int stall,
                           input int sum, input int cnt, input int ovf);
        tbl[t].n     = n;
        tbl[t].gaps  = gaps;
        tbl[t].stall = stall;
        tbl[t].sum   = sum;
        tbl[t].cnt   = cnt;
        tbl[t].ovf   = ovf;
    endtask

    initial begin
        int s;
        int c;
        int o;
        int n;

        // Directed vectors: operands and hand-computed totals
        set_vec(0, 1, 0, 0, 10, 1, 0);
        tbl[0].ops[0] = 4'd10;
        set_vec(1, 4, 0, 0, 24, 4, 0);
        tbl[1].ops[0] = 4'd11; tbl[1].ops[1] = 4'd2; tbl[1].ops[2] = 4'd4; tbl[1].ops[3] = 4'd7;
        set_vec(2, 4, 0, 0, 37, 4, 0);
        tbl[2].ops[0] = 4'd12; tbl[2].ops[1] = 4'd5; tbl[2].ops[2] = 4'd10; tbl[2].ops[3] = 4'd10;
        set_vec(3, 16, 0, 0, 240, 16, 0);
        for (int i = 0; i < 16; i++) tbl[3].ops[i] = 4'd15;
        set_vec(4, 17, 0, 0, 240, 16, 1);
        for (int i = 0; i < 17; i++) tbl[4].ops[i] = 4'd15;
        set_vec(5, 3, 1, 5, 22, 3, 0);
        tbl[5].ops[0] = 4'd4; tbl[5].ops[1] = 4'd6; tbl[5].ops[2] = 4'd12;
        set_vec(6, 4, 0, 0, 33, 4, 0);
        tbl[6].ops[0] = 4'd7; tbl[6].ops[1] = 4'd6; tbl[6].ops[2] = 4'd12; tbl[6].ops[3] = 4'd8;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Single operand: latency of two edges from accept to out_valid
        in_valid = 1'b1;
        in_data  = 4'd10;
        in_last  = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("lat_busy", 32'(busy), 32'd1);
        chk("lat_ready_resolve", 32'(in_ready), 32'd0);
        tick();
        chk("lat_valid_k1", 32'(out_valid), 32'd0);
        tick();
        chk("lat_valid_k2", 32'(out_valid), 32'd1);
        get_result(10, 1, 0, 0);

        // Vector table
        for (int t = 0; t < 6; t++) run_vec(t);

        // Reset mid-ACCUM after three operands
        cur_ops.delete();
        cur_ops.push_back(4'd3); cur_ops.push_back(4'd9); cur_ops.push_back(4'd1);
        send_ops(0, 1'b1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_sum", 32'(out_sum), 32'd0);
        chk("arst_out_count", 32'(out_count), 32'd0);
        chk("arst_out_ovf", 32'(out_ovf), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_rel_ready", 32'(in_ready), 32'd1);
        run_vec(6);

        // Idle inputs toggling without in_valid must not start or advance anything
        for (int i = 0; i < 4; i++) begin
            in_data = WIDTH'($urandom);
            in_last = 1'($urandom);
            tick();
            chk("idle_toggle_busy", 32'(busy), 32'd0);
            chk("idle_toggle_ready", 32'(in_ready), 32'd1);
        end
        in_last = 1'b0;
        cur_ops.delete();
        cur_ops.push_back(4'd9);
        send_ops(0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            in_data = WIDTH'($urandom);
            in_last = 1'b1;
            tick();
            chk("accum_toggle_busy", 32'(busy), 32'd1);
            chk("accum_toggle_valid", 32'(out_valid), 32'd0);
            chk("accum_toggle_ready", 32'(in_ready), 32'd1);
        end
        in_last = 1'b0;
        cur_ops.delete();
        cur_ops.push_back(4'd5);
        send_ops(0, 1'b0);
        get_result(14, 2, 0, 0);

        // Random transactions against the reference model
        for (int t = 0; t < 30; t++) begin
            n = $urandom_range(1, 20);
            cur_ops.delete();
            for (int i = 0; i < n; i++) cur_ops.push_back(WIDTH'($urandom));
            model(s, c, o);
            send_ops(2, 1'b0);
            get_result(s, c, o, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
